// File: rtl/visumon_debug_arbiter_pkg.sv
// Shared visuMon types: debug payload, colour enum and the debug-port arbiter state set.
package visumon_debug_arbiter_pkg;

  localparam int unsigned VISUMON_ARB_MAX_REQ = 8;

  typedef enum logic [2:0] {
    Black,
    Red,
    Green,
    Yellow,
    Blue,
    Magenta,
    Cyan,
    White
  } color_e;

  // 19-bit payload written into visuMon's per-LED debug table.
  typedef struct packed {
    logic [7:0] ledNo;
    color_e     color;
    logic [7:0] status;
  } debugInfo_t;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StRecover
  } arb_state_t;

  function automatic logic arb_busy(arb_state_t st);
    return st != StIdle;
  endfunction

endpackage

// File: rtl/visumon_debug_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after last_i, wrapping.
module visumon_debug_arbiter_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = last_i;
    // Walk the offsets from farthest to nearest so the nearest set request wins.
    for (int k = int'(NumReq); k >= 1; k--) begin
      logic [IdxW-1:0] cand;
      cand = IdxW'((int'(last_i) + k) % int'(NumReq));
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/visumon_debug_arbiter.sv
// Round-robin arbiter for the visuMon debug-write port; one-cycle o_cs pulses plus recovery.
// Optional write deduplication is enabled with the VISUMON_ARB_DEDUP_EN macro.
module visumon_debug_arbiter
  import visumon_debug_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                     i_clk25Mhz,
  input  logic                     i_reset,
  input  logic       [NUM_REQ-1:0] i_req,
  input  debugInfo_t [NUM_REQ-1:0] i_debugInfo,
  output logic       [NUM_REQ-1:0] o_ack,
  output logic                     o_cs,
  output debugInfo_t               o_debugInfo,
  output logic                     o_busy
`ifdef VISUMON_ARB_DEDUP_EN
  ,
  output logic       [15:0]        o_dedupCount
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  debugInfo_t         info_q, info_d;
  logic               cs_q, cs_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               arb_en;
  logic               grant;
  logic               dup;

  visumon_debug_arbiter_rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IDX_W)
  ) u_rr_pick (
    .req_i   (i_req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Requests are only sampled outside the strobe cycle.
  assign arb_en = (state_q != StAssert);
  assign grant  = arb_en && pick_valid;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    info_d  = info_q;
    cs_d    = 1'b1;
    ack_d   = '0;
    case (state_q)
      StIdle, StRecover: begin
        if (pick_valid) begin
          state_d         = StAssert;
          last_d          = pick_idx;
          info_d          = i_debugInfo[pick_idx];
          ack_d[pick_idx] = 1'b1;
          cs_d            = dup;
        end else begin
          state_d = StIdle;
        end
      end
      StAssert: state_d = StRecover;
      default:  state_d = StIdle;
    endcase
  end

  // cs and ack are flops with async reset so a reset mid-write lifts o_cs without a glitch.
  always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      last_q  <= IDX_W'(NUM_REQ - 1);
      info_q  <= '0;
      cs_q    <= 1'b1;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      info_q  <= info_d;
      cs_q    <= cs_d;
      ack_q   <= ack_d;
    end
  end

  assign o_cs        = cs_q;
  assign o_ack       = ack_q;
  assign o_debugInfo = info_q;
  assign o_busy      = arb_busy(state_q);

`ifdef VISUMON_ARB_DEDUP_EN
  debugInfo_t [NUM_REQ-1:0] shadow_q, shadow_d;
  logic       [NUM_REQ-1:0] shadow_vld_q, shadow_vld_d;
  logic       [15:0]        dedup_cnt_q, dedup_cnt_d;

  assign dup = shadow_vld_q[pick_idx] && (shadow_q[pick_idx] == i_debugInfo[pick_idx]);

  // Shadow is written on the edge entering the strobe cycle; no new grant can observe it earlier.
  always_comb begin
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    dedup_cnt_d  = dedup_cnt_q;
    if (grant) begin
      if (dup) begin
        if (dedup_cnt_q != 16'hFFFF) begin
          dedup_cnt_d = dedup_cnt_q + 16'd1;
        end
      end else begin
        shadow_d[pick_idx]     = i_debugInfo[pick_idx];
        shadow_vld_d[pick_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
    if (!i_reset) begin
      shadow_q     <= '0;
      shadow_vld_q <= '0;
      dedup_cnt_q  <= '0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      dedup_cnt_q  <= dedup_cnt_d;
    end
  end

  assign o_dedupCount = dedup_cnt_q;
`else
  assign dup = 1'b0;
`endif

endmodule

// File: tb/tb_visumon_debug_arbiter.sv
// Self-checking bench for visumon_debug_arbiter: directed table, corner sequences, random vs model.
module tb_visumon_debug_arbiter;
  import visumon_debug_arbiter_pkg::*;

  localparam int N = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req   = '0;
  debugInfo_t [N-1:0] info = '0;
  logic [N-1:0]     ack;
  logic             cs;
  debugInfo_t       dout;
  logic             busy;
`ifdef VISUMON_ARB_DEDUP_EN
  logic [15:0]      dcount;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #20 clk = ~clk;

  visumon_debug_arbiter #(
    .NUM_REQ (N)
  ) dut (
    .i_clk25Mhz   (clk),
    .i_reset      (rst_n),
    .i_req        (req),
    .i_debugInfo  (info),
    .o_ack        (ack),
    .o_cs         (cs),
    .o_debugInfo  (dout),
    .o_busy       (busy)
`ifdef VISUMON_ARB_DEDUP_EN
    ,
    .o_dedupCount (dcount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic int rr_next(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (((r >> c) & 4'b0001) != 4'b0000) return c;
    end
    return -1;
  endfunction

  function automatic debugInfo_t pay(input int row, input int i);
    debugInfo_t p;
    p.ledNo  = 8'(row * 8 + i);
    p.color  = color_e'(3'(i + 1));
    p.status = 8'(row ^ 8'h5A);
    return p;
  endfunction

  function automatic debugInfo_t rand_info();
    debugInfo_t p;
    p.ledNo  = 8'($urandom_range(0, 3));
    p.color  = color_e'(3'($urandom_range(0, 1)));
    p.status = 8'($urandom_range(0, 1));
    return p;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic         cs;
    logic         busy;
  } vec_t;

  vec_t tbl[19];

  // Model state for the random phase
  int           m_last;
  logic         m_in_assert;
  debugInfo_t   m_data;
  logic [N-1:0] e_ack;
  logic         e_cs;
  logic         e_busy;
  debugInfo_t   m_sh[N];
  logic [N-1:0] m_sv;
  int unsigned  m_cnt;

  initial begin
    debugInfo_t exp_d;
    debugInfo_t d1;

    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0001, 1'b0, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[3]  = '{4'b1111, 4'b0010, 1'b0, 1'b1};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b1};
    tbl[5]  = '{4'b1111, 4'b0100, 1'b0, 1'b1};
    tbl[6]  = '{4'b1111, 4'b0000, 1'b1, 1'b1};
    tbl[7]  = '{4'b1111, 4'b1000, 1'b0, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0000, 1'b1, 1'b1};
    tbl[9]  = '{4'b1111, 4'b0001, 1'b0, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[12] = '{4'b0100, 4'b0100, 1'b0, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[14] = '{4'b0101, 4'b0001, 1'b0, 1'b1};
    tbl[15] = '{4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[16] = '{4'b1001, 4'b1000, 1'b0, 1'b1};
    tbl[17] = '{4'b0000, 4'b0000, 1'b1, 1'b1};
    tbl[18] = '{4'b0000, 4'b0000, 1'b1, 1'b0};

    // Reset held for 10 cycles
    #1 rst_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rst_cs", 32'(cs), 32'd1);
      check("rst_ack_busy", {28'd0, ack | {3'b000, busy}}, 32'd0);
    end
    check("rst_data", 32'(dout), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_cs", 32'(cs), 32'd1);
    end

    // Single write from requester 0
    d1.ledNo = 8'd1; d1.color = Red; d1.status = 8'd1;
    req = 4'b0001; info[0] = d1;
    @(negedge clk);
    check("single_cs", 32'(cs), 32'd0);
    check("single_ack", 32'(ack), 32'd1);
    check("single_data", 32'(dout), 32'(d1));
    req = 4'b0000;
    @(negedge clk);
    check("single_rec_cs", 32'(cs), 32'd1);
    check("single_rec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_hold_data", 32'(dout), 32'(d1));

    // Table: one row per cycle, outputs checked the cycle after the row's inputs
    exp_d = d1;
    for (int r = 0; r <= 19; r++) begin
      @(negedge clk);
      if (r > 0) begin
        for (int i = 0; i < N; i++) if (tbl[r-1].ack[i]) exp_d = pay(r - 1, i);
        check($sformatf("tbl%0d_ack", r - 1), 32'(ack), 32'(tbl[r-1].ack));
        check($sformatf("tbl%0d_cs", r - 1), 32'(cs), 32'(tbl[r-1].cs));
        check($sformatf("tbl%0d_busy", r - 1), 32'(busy), 32'(tbl[r-1].busy));
        check($sformatf("tbl%0d_data", r - 1), 32'(dout), 32'(exp_d));
      end
      if (r < 19) begin
        req = tbl[r].req;
        for (int i = 0; i < N; i++) info[i] = pay(r, i);
      end
    end
    req = '0;

    // Reset in the middle of a strobe cycle
    @(negedge clk);
    req = 4'b0010;
    @(posedge clk);
    #5;
    check("midwr_pre_cs", 32'(cs), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midwr_cs", 32'(cs), 32'd1);
    check("midwr_ack", 32'(ack), 32'd0);
    check("midwr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req = 4'b0000;
    check("midwr_hold_cs", 32'(cs), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b1111;
    for (int i = 0; i < N; i++) info[i] = pay(40, i);
    @(negedge clk);
    check("midwr_prio0", 32'(ack), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    // Same payload written twice by requester 1
    d1.ledNo = 8'd2; d1.color = Green; d1.status = 8'd0;
    req = 4'b0010; info[1] = d1;
    @(negedge clk);
    check("dup1_ack", 32'(ack), 32'd2);
    check("dup1_cs", 32'(cs), 32'd0);
`ifdef VISUMON_ARB_DEDUP_EN
    check("dup1_cnt", 32'(dcount), 32'd0);
`endif
    @(negedge clk);
    check("dup_rec_cs", 32'(cs), 32'd1);
    @(negedge clk);
    req = 4'b0000;
    check("dup2_ack", 32'(ack), 32'd2);
`ifdef VISUMON_ARB_DEDUP_EN
    check("dup2_cs", 32'(cs), 32'd1);
    check("dup2_cnt", 32'(dcount), 32'd1);
`else
    check("dup2_cs", 32'(cs), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);

    // Random phase against the behavioural model, from a fresh reset
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n       = 1'b1;
    m_last      = N - 1;
    m_in_assert = 1'b0;
    m_data      = '0;
    e_ack       = '0;
    e_cs        = 1'b1;
    e_busy      = 1'b0;
    m_sv        = '0;
    m_cnt       = 0;
    for (int i = 0; i < N; i++) m_sh[i] = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int w;
      @(negedge clk);
      if (cyc > 0) begin
        check("rnd_ack", 32'(ack), 32'(e_ack));
        check("rnd_cs", 32'(cs), 32'(e_cs));
        check("rnd_busy", 32'(busy), 32'(e_busy));
        check("rnd_data", 32'(dout), 32'(m_data));
`ifdef VISUMON_ARB_DEDUP_EN
        check("rnd_cnt", 32'(dcount), m_cnt);
`endif
      end
      for (int i = 0; i < N; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 3) != 0) info[i] = rand_info();
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]  = 1'b1;
          info[i] = rand_info();
        end
      end
      if (m_in_assert) begin
        e_ack       = '0;
        e_cs        = 1'b1;
        e_busy      = 1'b1;
        m_in_assert = 1'b0;
      end else begin
        w = rr_next(req, m_last);
        if (w >= 0) begin
          e_ack       = 4'(1 << w);
          e_cs        = 1'b0;
          e_busy      = 1'b1;
          m_data      = info[w];
          m_last      = w;
          m_in_assert = 1'b1;
`ifdef VISUMON_ARB_DEDUP_EN
          if (m_sv[w] && m_sh[w] == info[w]) begin
            e_cs = 1'b1;
            if (m_cnt < 65535) m_cnt++;
          end else begin
            m_sh[w] = info[w];
            m_sv[w] = 1'b1;
          end
`endif
        end else begin
          e_ack  = '0;
          e_cs   = 1'b1;
          e_busy = 1'b0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
